// File: rtl/i2c_master_tx.sv
// I2C write-transaction engine: START, address+W, ACK check, FIFO-fed data bytes, STOP.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_LOAD,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [6:0]       r_addr;
  logic             r_ack_smp;
  logic             r_scl;
  logic             r_sda;
  logic             r_busy;
  logic             r_done;
  logic             r_nack;
  logic             r_fifo_rd;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_q_nxt;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       w_shift_nxt;
  logic [6:0]       w_addr_nxt;
  logic             w_ack_nxt;
  logic             w_scl_nxt;
  logic             w_sda_nxt;
  logic             w_done_nxt;
  logic             w_nack_nxt;
  logic             w_rd_nxt;
  logic             w_tick;
  logic             w_bit_end;

  assign w_tick    = (r_div == DIV_MAX);
  assign w_bit_end = w_tick && (r_q == 2'd3);

  // Next-state, quarter-phase line patterns and transaction bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_tick ? '0 : r_div + DIV_W'(1);
    w_q_nxt     = w_tick ? r_q + 2'd1 : r_q;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_ack_nxt   = r_ack_smp;
    w_scl_nxt   = 1'b1;
    w_sda_nxt   = 1'b1;
    w_done_nxt  = 1'b0;
    w_nack_nxt  = r_nack;
    w_rd_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        w_q_nxt   = 2'd0;
        w_bit_nxt = 3'd0;
        if (start) begin
          w_addr_nxt  = slave_addr;
          w_nack_nxt  = 1'b0;
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        w_scl_nxt = (r_q != 2'd3);
        w_sda_nxt = !r_q[1];
        if (w_bit_end) begin
          w_shift_nxt = {r_addr, 1'b0};
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_ADDR;
        end
      end

      S_ADDR, S_DATA: begin
        w_scl_nxt = r_q[1];
        w_sda_nxt = r_shift[7];
        if (w_bit_end) begin
          w_shift_nxt = {r_shift[6:0], 1'b0};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
          end
        end
      end

      S_ADDR_ACK, S_DATA_ACK: begin
        w_scl_nxt = r_q[1];
        if (w_tick && (r_q == 2'd2)) begin
          w_ack_nxt = sda_in;
        end
        if (w_bit_end) begin
          if (r_ack_smp) begin
            w_nack_nxt  = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        w_scl_nxt = 1'b0;
        w_div_nxt = '0;
        w_q_nxt   = 2'd0;
        if (fifo_empty) begin
          w_state_nxt = S_STOP;
        end else begin
          w_rd_nxt    = 1'b1;
          w_shift_nxt = fifo_data;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end
      end

      S_STOP: begin
        w_scl_nxt = (r_q != 2'd0);
        w_sda_nxt = r_q[1];
        if (w_bit_end) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_addr    <= 7'h00;
      r_ack_smp <= 1'b0;
      r_scl     <= 1'b1;
      r_sda     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
      r_fifo_rd <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_q       <= w_q_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_ack_smp <= w_ack_nxt;
      r_scl     <= w_scl_nxt;
      r_sda     <= w_sda_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
      r_nack    <= w_nack_nxt;
      r_fifo_rd <= w_rd_nxt;
    end
  end

  assign scl_out = r_scl;
  assign sda_out = r_sda;
  assign busy    = r_busy;
  assign done    = r_done;
  assign nack    = r_nack;
  assign fifo_rd = r_fifo_rd;

endmodule
